// File: rtl/qrd_array_ctrl.sv
// qrd_array_ctrl: run controller for a triangular QR-decomposition systolic array.
// Accepts a configured number of (x, y) samples, feeds them into the PE rows
// through a skew register, drains in-flight tokens, then raises irq until acked.
module qrd_array_ctrl #(
  parameter int N_DIM = 3,
  parameter int UPD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [UPD_W-1:0] cfg_n_updates,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_DIM-1:0] row_en,
  output logic             out_valid,
  output logic             freeze,
  output logic             busy,
  output logic [UPD_W-1:0] upd_cnt,
  output logic             irq,
  input  logic             irq_ack
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [UPD_W-1:0] CNT_ZERO = {UPD_W{1'b0}};
  localparam logic [UPD_W-1:0] CNT_ONE  = {{(UPD_W-1){1'b0}}, 1'b1};
  localparam logic [UPD_W-1:0] CNT_MAX  = {UPD_W{1'b1}};
  localparam logic [N_DIM:0]   SK_ZERO  = {(N_DIM+1){1'b0}};

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [N_DIM:0]   sk_r;
  logic [N_DIM:0]   sk_s;
  logic [UPD_W-1:0] target_r;
  logic [UPD_W-1:0] cnt_r;
  logic             irq_r;
  logic             accept_s;
  logic             last_s;

  // Accept decode, next skew contents and detection of the final sample of a run.
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    if (state_r == S_RUN) begin
      accept_s = in_valid;
      last_s   = in_valid && (cnt_r == (target_r - CNT_ONE));
    end else begin
      accept_s = 1'b0;
      last_s   = 1'b0;
    end
    sk_s = {sk_r[N_DIM-1:0], accept_s};
  end

  // Next-state logic; DRAIN looks ahead so DONE coincides with the first empty-skew cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (cfg_n_updates != CNT_ZERO) state_s = S_RUN;
          else                           state_s = S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s || abort) state_s = S_DRAIN;
        else                 state_s = S_RUN;
      end
      S_DRAIN: begin
        if (sk_s == SK_ZERO) state_s = S_DONE;
        else                 state_s = S_DRAIN;
      end
      S_DONE: begin
        if (irq_ack) state_s = S_IDLE;
        else         state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, skew pipeline, target/count and irq registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      sk_r     <= SK_ZERO;
      target_r <= CNT_ZERO;
      cnt_r    <= CNT_ZERO;
      irq_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      sk_r    <= sk_s;
      irq_r   <= (state_r == S_DONE) && !irq_ack;
      if ((state_r == S_IDLE) && start) begin
        cnt_r <= CNT_ZERO;
        if (cfg_n_updates != CNT_ZERO) target_r <= cfg_n_updates;
      end else if (accept_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign in_ready  = (state_r == S_RUN);
  assign row_en    = sk_r[N_DIM-1:0];
  assign out_valid = sk_r[N_DIM];
  assign freeze    = (sk_r == SK_ZERO);
  assign busy      = (state_r != S_IDLE);
  assign upd_cnt   = cnt_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_qrd_array_ctrl.sv
// Testbench for qrd_array_ctrl (N_DIM=3): per-scenario tasks with inline checks
// and an out_valid scoreboard holding the expected output cycle of each token.
module tb_qrd_array_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_n_updates = 16'd0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        irq_ack = 1'b0;
  logic        in_ready, out_valid, freeze, busy, irq;
  logic [2:0]  row_en;
  logic [15:0] upd_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ov_q[$];
  int acc_q[$];

  qrd_array_ctrl #(.N_DIM(3), .UPD_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_n_updates(cfg_n_updates),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .row_en(row_en),
    .out_valid(out_valid), .freeze(freeze), .busy(busy), .upd_cnt(upd_cnt),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every out_valid pulse must match the oldest expected output cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      total++;
      if (ov_q.size() == 0) begin
        bad++;
        $display("FAIL out_valid_unexpected cyc=%0d got=1 exp=0", cyc);
      end else begin
        int e;
        e = ov_q.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL out_valid_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end
  end

  // Token with accept cycle a occupies skew stage i during cycle a+1+i.
  function automatic bit sk_exp(int c, int i);
    foreach (acc_q[j]) if (c == acc_q[j] + 1 + i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] row_exp(int c);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = sk_exp(c, i);
    return r;
  endfunction

  function automatic logic freeze_exp(int c);
    for (int i = 0; i <= 3; i++) if (sk_exp(c, i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if ({in_ready, row_en, out_valid, freeze, busy, irq} !== 8'b0_000_0_1_0_0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", {in_ready, row_en, out_valid, freeze, busy, irq}, 8'b0_000_0_1_0_0);
    end
    total++; if (upd_cnt !== 16'd0) begin bad++; $display("FAIL reset_upd_cnt got=%0d exp=0", upd_cnt); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    acc_q.delete();
    start = 1'b1; cfg_n_updates = 16'd4; in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      start = 1'b0;
      total++; if (in_ready !== (k <= 4)) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=%b", k, in_ready, (k <= 4)); end
      total++; if (row_en !== row_exp(cyc)) begin bad++; $display("FAIL b2b_row_en k=%0d got=%b exp=%b", k, row_en, row_exp(cyc)); end
      total++; if (freeze !== freeze_exp(cyc)) begin bad++; $display("FAIL b2b_freeze k=%0d got=%b exp=%b", k, freeze, freeze_exp(cyc)); end
      total++; if (irq !== (k >= 10)) begin bad++; $display("FAIL b2b_irq k=%0d got=%b exp=%b", k, irq, (k >= 10)); end
      if (k <= 4) begin acc_q.push_back(cyc); ov_q.push_back(cyc + 4); end
    end
    in_valid = 1'b0;
    total++; if (upd_cnt !== 16'd4) begin bad++; $display("FAIL b2b_upd_cnt got=%0d exp=4", upd_cnt); end
    do_ack();
    total++; if ({busy, irq} !== 2'b00) begin bad++; $display("FAIL b2b_ack got=%b exp=00", {busy, irq}); end
    total++; if (upd_cnt !== 16'd4) begin bad++; $display("FAIL b2b_cnt_hold got=%0d exp=4", upd_cnt); end
    total++; if (ov_q.size() !== 0) begin bad++; $display("FAIL b2b_missing_out got=%0d exp=0", ov_q.size()); end
  endtask

  task automatic test_gapped();
    logic [4:0] pat;
    pat = 5'b10101;
    acc_q.delete();
    start = 1'b1; cfg_n_updates = 16'd3;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start = 1'b0;
      in_valid = (k <= 5) ? pat[k-1] : 1'b0;
      total++; if (in_ready !== (k <= 5)) begin bad++; $display("FAIL gap_in_ready k=%0d got=%b exp=%b", k, in_ready, (k <= 5)); end
      total++; if (row_en !== row_exp(cyc)) begin bad++; $display("FAIL gap_row_en k=%0d got=%b exp=%b", k, row_en, row_exp(cyc)); end
      total++; if (freeze !== freeze_exp(cyc)) begin bad++; $display("FAIL gap_freeze k=%0d got=%b exp=%b", k, freeze, freeze_exp(cyc)); end
      total++; if (irq !== (k >= 11)) begin bad++; $display("FAIL gap_irq k=%0d got=%b exp=%b", k, irq, (k >= 11)); end
      if (k <= 5 && in_valid) begin acc_q.push_back(cyc); ov_q.push_back(cyc + 4); end
    end
    total++; if (upd_cnt !== 16'd3) begin bad++; $display("FAIL gap_upd_cnt got=%0d exp=3", upd_cnt); end
    do_ack();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL gap_ack_busy got=%b exp=0", busy); end
    total++; if (ov_q.size() !== 0) begin bad++; $display("FAIL gap_missing_out got=%0d exp=0", ov_q.size()); end
  endtask

  task automatic test_abort();
    acc_q.delete();
    start = 1'b1; cfg_n_updates = 16'd10; in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = 1'b0;
      abort = (k == 2);
      total++; if (in_ready !== (k <= 2)) begin bad++; $display("FAIL abort_in_ready k=%0d got=%b exp=%b", k, in_ready, (k <= 2)); end
      total++; if (row_en !== row_exp(cyc)) begin bad++; $display("FAIL abort_row_en k=%0d got=%b exp=%b", k, row_en, row_exp(cyc)); end
      total++; if (irq !== (k >= 8)) begin bad++; $display("FAIL abort_irq k=%0d got=%b exp=%b", k, irq, (k >= 8)); end
      if (k <= 2) begin acc_q.push_back(cyc); ov_q.push_back(cyc + 4); end
    end
    in_valid = 1'b0;
    total++; if (upd_cnt !== 16'd2) begin bad++; $display("FAIL abort_upd_cnt got=%0d exp=2", upd_cnt); end
    do_ack();
    total++; if (ov_q.size() !== 0) begin bad++; $display("FAIL abort_missing_out got=%0d exp=0", ov_q.size()); end
  endtask

  task automatic test_zero_target();
    start = 1'b1; cfg_n_updates = 16'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start = 1'b0;
      total++; if ({in_ready, row_en} !== 4'b0) begin bad++; $display("FAIL zero_feed k=%0d got=%b exp=0000", k, {in_ready, row_en}); end
      total++; if (irq !== (k >= 2)) begin bad++; $display("FAIL zero_irq k=%0d got=%b exp=%b", k, irq, (k >= 2)); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy k=%0d got=%b exp=1", k, busy); end
    end
    total++; if (upd_cnt !== 16'd0) begin bad++; $display("FAIL zero_upd_cnt got=%0d exp=0", upd_cnt); end
    do_ack();
    total++; if ({busy, irq} !== 2'b00) begin bad++; $display("FAIL zero_ack got=%b exp=00", {busy, irq}); end
  endtask

  task automatic test_reset_midrun();
    acc_q.delete();
    start = 1'b1; cfg_n_updates = 16'd5; in_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      start = 1'b0;
      if (k <= 3) begin
        total++; if (row_en !== row_exp(cyc)) begin bad++; $display("FAIL rst_pre_row_en k=%0d got=%b exp=%b", k, row_en, row_exp(cyc)); end
      end else begin
        total++; if ({in_ready, row_en, out_valid, freeze, busy, irq} !== 8'b0_000_0_1_0_0) begin
          bad++; $display("FAIL rst_post_outputs k=%0d got=%b exp=%b", k, {in_ready, row_en, out_valid, freeze, busy, irq}, 8'b0_000_0_1_0_0);
        end
        total++; if (upd_cnt !== 16'd0) begin bad++; $display("FAIL rst_post_upd_cnt k=%0d got=%0d exp=0", k, upd_cnt); end
      end
      if (k <= 2) acc_q.push_back(cyc);
      if (k == 3) rst = 1'b1;
      if (k == 4) begin rst = 1'b0; in_valid = 1'b0; end
    end
  endtask

  task automatic test_ignored_controls();
    acc_q.delete();
    start = 1'b1; cfg_n_updates = 16'd3; in_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      start = (k == 1);
      irq_ack = (k == 1);
      cfg_n_updates = (k == 1) ? 16'd1 : 16'd3;
      in_valid = (k >= 3 && k <= 5);
      total++; if (in_ready !== (k <= 5)) begin bad++; $display("FAIL ign_in_ready k=%0d got=%b exp=%b", k, in_ready, (k <= 5)); end
      total++; if (irq !== (k >= 11)) begin bad++; $display("FAIL ign_irq k=%0d got=%b exp=%b", k, irq, (k >= 11)); end
      if (k >= 3 && k <= 5) begin acc_q.push_back(cyc); ov_q.push_back(cyc + 4); end
    end
    start = 1'b0; irq_ack = 1'b0; in_valid = 1'b0;
    total++; if (upd_cnt !== 16'd3) begin bad++; $display("FAIL ign_upd_cnt got=%0d exp=3", upd_cnt); end
    do_ack();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_ack_busy got=%b exp=0", busy); end
    total++; if (ov_q.size() !== 0) begin bad++; $display("FAIL ign_missing_out got=%0d exp=0", ov_q.size()); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_zero_target();
    test_reset_midrun();
    test_ignored_controls();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qrd_array_ctrl.md
QRD_ARRAY_CTRL -- requirements
Module: qrd_array_ctrl

Interface
REQ-001 Parameter N_DIM, default 3, meaning the input dimension and number of PE rows in the triangular array.
REQ-002 Parameter UPD_W, default 16, meaning the width of the update-count configuration and status.
REQ-003 clk  input  1  meaning the single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  meaning synchronous, active-high reset.
REQ-005 start  input  1  meaning a pulse that begins an adaptation run; honoured only in IDLE.
REQ-006 cfg_n_updates  input  UPD_W  meaning the number of samples to accept in the run; sampled on start.
REQ-007 abort  input  1  meaning stop accepting samples and drain the array; honoured only in RUN.
REQ-008 in_valid  input  1  meaning the source presents an (x, y) sample.
REQ-009 in_ready  output  1  meaning the controller accepts the sample this cycle.
REQ-010 row_en  output  N_DIM  meaning bit i strobes sample entry into PE row i (skewed feed).
REQ-011 out_valid  output  1  meaning the a-posteriori error e is valid at the array output.
REQ-012 freeze  output  1  meaning a global hold to all PEs; 1 means PEs keep their state.
REQ-013 busy  output  1  meaning the state is not IDLE.
REQ-014 upd_cnt  output  UPD_W  meaning the number of samples accepted in the current or last run.
REQ-015 irq  output  1  meaning the run is complete and the weights are stable; held until acknowledged.
REQ-016 irq_ack  input  1  meaning clear irq and return to IDLE; honoured only in DONE.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE, with exactly one state active.
REQ-018 IDLE: start with cfg_n_updates!=0 SHALL latch the target, clear upd_cnt and enter RUN; start with cfg_n_updates==0 SHALL clear upd_cnt and enter DONE.
REQ-019 in_ready SHALL be 1 only in RUN; an accept is in_valid && in_ready.
REQ-020 Each accept SHALL increment upd_cnt by 1.
REQ-021 RUN SHALL enter DRAIN in the cycle after the accept that makes upd_cnt equal the target; no further accept is possible in DRAIN.
REQ-022 abort in RUN SHALL enter DRAIN next cycle; an accept in the same cycle as abort SHALL still count and propagate.
REQ-023 The skew register sk[N_DIM:0] SHALL update as sk[0]<=accept and sk[i]<=sk[i-1]; row_en[i]=sk[i] and out_valid=sk[N_DIM].
REQ-024 Latency: an accept at cycle t SHALL give row_en[i] at t+1+i and out_valid at t+1+N_DIM; back-to-back accepts SHALL give back-to-back strobes.
REQ-025 freeze SHALL equal 1 exactly when sk is all zero, in every state.
REQ-026 DRAIN SHALL enter DONE in the first cycle in which sk is all zero.
REQ-027 irq SHALL be a registered output, set on entry to DONE and held while in DONE.
REQ-028 irq_ack in DONE SHALL clear irq and enter IDLE next cycle; upd_cnt SHALL hold its value until the next start.
REQ-029 start outside IDLE, abort outside RUN and irq_ack outside DONE SHALL be ignored.
REQ-030 upd_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-031 While rst=1, the controller SHALL force state=IDLE, sk=0, upd_cnt=0 and irq=0, so that in_ready=0, row_en=0, out_valid=0, freeze=1 and busy=0.
REQ-032 rst asserted mid-RUN or mid-DRAIN SHALL discard in-flight tokens without emitting further row_en or out_valid strobes.

Verification (N_DIM=3)
REQ-033 start, cfg_n_updates=4, in_valid held at 1 -> accepts in 4 consecutive cycles; row_en[0] high for 4 cycles starting 1 cycle after the first accept; out_valid high for 4 cycles starting 4 cycles after the first accept; irq rises 1 cycle after sk empties; upd_cnt=4.
REQ-034 cfg_n_updates=3, in_valid toggling 1,0,1,0,1 -> gapped row_en pattern mirrors the gaps; freeze=1 during each gap once sk is empty; exactly 3 out_valid pulses.
REQ-035 cfg_n_updates=10, abort asserted with an accept on the 2nd sample -> upd_cnt=2, 2 out_valid pulses, DONE, irq=1.
REQ-036 start with cfg_n_updates=0 -> no row_en; irq=1 two cycles after start; irq_ack -> IDLE, busy=0.
REQ-037 rst pulse while 2 tokens are in sk -> next cycle all outputs at reset values; no out_valid for those tokens.
REQ-038 start pulsed during RUN and irq_ack pulsed during RUN -> no effect on upd_cnt, the target or the state.
